mio_arbiter: RTL and testbench

Shares the single external memory/MIO port between the pipeline core's instruction-fetch path and its load/store path. Accepts one request at a time from two requesters, gives data accesses priority with a fetch-starvation guard, runs a variable-latency req/ready handshake to memory with a timeout, and returns read data plus a one-cycle ready pulse to the owner. Sits between `pcpu_core` (fetch and data ports) and the memory/IO bus, and drives the core's pipeline stall.

---
 rtl/mio_arbiter_if.sv | 36 +++
 rtl/mio_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mio_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mio_arbiter_if.sv
// Signal bundle around the MIO arbiter: fetch port, data port and the shared memory port.
interface mio_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall;
    logic        bus_err;
    logic        owner_d;

    // Arbiter view
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata,
               stall, bus_err, owner_d
    );

    // Core and memory view
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata,
               stall, bus_err, owner_d
    );
endinterface

// File: rtl/mio_arbiter.sv
// Shares one memory port between fetch and load/store: data priority with a fetch
// starvation guard, variable-latency req/ready handshake and a BUSY timeout.
module mio_arbiter #(
    parameter int unsigned STREAK_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic         clk,
    input  logic         rst,
    mio_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    state_e      state_q,     state_d;
    logic [3:0]  streak_q,    streak_d;
    logic [7:0]  tmo_q,       tmo_d;
    logic        own_data_q,  own_data_d;
    logic        mem_req_q,   mem_req_d;
    logic        mem_we_q,    mem_we_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] if_rdata_q,  if_rdata_d;
    logic [31:0] d_rdata_q,   d_rdata_d;
    logic        if_ready_q,  if_ready_d;
    logic        d_ready_q,   d_ready_d;
    logic        bus_err_q,   bus_err_d;
    logic        grant_data;

    // Arbitration, handshake sequencing and response capture
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        tmo_d       = tmo_q;
        own_data_d  = own_data_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        bus_err_d   = 1'b0;
        grant_data  = bus.d_req && !(bus.if_req && (streak_q == STREAK_LIM));

        case (state_q)
            ST_IDLE: begin
                if (grant_data) begin
                    own_data_d  = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    tmo_d       = 8'd0;
                    state_d     = ST_BUSY;
                    // Only data grants that overtake a waiting fetch count toward the guard
                    if (bus.if_req && (streak_q != 4'hF)) begin
                        streak_d = streak_q + 4'd1;
                    end else begin
                        streak_d = streak_q;
                    end
                end else if (bus.if_req) begin
                    own_data_d = 1'b0;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = bus.if_addr;
                    tmo_d      = 8'd0;
                    streak_d   = 4'd0;
                    state_d    = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_BUSY: begin
                if (bus.mem_ready) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = ST_RESP;
                    if (!mem_we_q && own_data_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end else if (!mem_we_q) begin
                        if_rdata_d = bus.mem_rdata;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                    if (own_data_q) begin
                        d_ready_d = 1'b1;
                    end else begin
                        if_ready_d = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = ST_RESP;
                    if (!mem_we_q && own_data_q) begin
                        d_rdata_d = 32'h0000_0000;
                    end else if (!mem_we_q) begin
                        if_rdata_d = 32'h0000_0000;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                    if (own_data_q) begin
                        d_ready_d = 1'b1;
                    end else begin
                        if_ready_d = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end

            ST_RESP: begin
                own_data_d = 1'b0;
                state_d    = ST_IDLE;
            end

            default: begin
                own_data_d = 1'b0;
                mem_req_d  = 1'b0;
                mem_we_d   = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            streak_q    <= 4'd0;
            tmo_q       <= 8'd0;
            own_data_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            if_rdata_q  <= 32'h0000_0000;
            d_rdata_q   <= 32'h0000_0000;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            tmo_q       <= tmo_d;
            own_data_q  <= own_data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.bus_err   = bus_err_q;
    assign bus.owner_d   = own_data_q;
    assign bus.stall     = (bus.if_req & ~if_ready_q) | (bus.d_req & ~d_ready_q);

endmodule

// File: tb/tb_mio_arbiter.sv
// Scoreboarded bench for mio_arbiter: directed cases plus randomized fetch/data traffic
// against a memory whose latency is a function of the address.
module tb_mio_arbiter;
    localparam int STREAK = 4;
    localparam int TMO    = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mio_arbiter_if bus();

    mio_arbiter #(.STREAK_MAX(STREAK), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t       iq[$];
    resp_t       dq[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          dir_lat  = 0;
    bit          late_pulse = 1'b0;
    logic [31:0] mem_store [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];
    logic [31:0] exp_d_rdata = 32'h0;
    string       gseq = "";
    bit          rec_gseq = 1'b0;
    int          streak_m = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic flag_fail(input string name, input string what);
        n_checks++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Memory latency in cycles from the address; anything above TMO never answers
    function automatic int lat_of(input logic [31:0] a);
        int v;
        v = int'(a[5:2]);
        if (dir_lat != 0) return dir_lat;
        if (v >= 14) return 99;
        return (v % 8) + 1;
    endfunction

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hC0DE_5A00;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    task automatic wait_ready(input bit is_d, input string nm);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 300) begin
            @(posedge clk); #1;
            n++;
            seen = is_d ? bus.d_ready : bus.if_ready;
        end
        if (!seen) flag_fail(nm, "no ready pulse within 300 cycles, required one");
    endtask

    task automatic data_txn(input bit we, input logic [31:0] a, input logic [31:0] wd);
        resp_t e;
        e.err = (lat_of(a) > TMO);
        if (we) begin
            if (!e.err) ref_mem[a] = wd;
            e.rdata = exp_d_rdata;
        end else begin
            e.rdata = e.err ? 32'h0 : ref_read(a);
            exp_d_rdata = e.rdata;
        end
        dq.push_back(e);
        bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
        wait_ready(1'b1, "d_ready_wait");
    endtask

    task automatic fetch_txn(input logic [31:0] a);
        resp_t e;
        e.err   = (lat_of(a) > TMO);
        e.rdata = e.err ? 32'h0 : ref_read(a);
        iq.push_back(e);
        bus.if_req = 1'b1; bus.if_addr = a;
        wait_ready(1'b0, "if_ready_wait");
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_mem_req"},   bus.mem_req,   32'h0);
        check({tag, "_mem_we"},    bus.mem_we,    32'h0);
        check({tag, "_mem_addr"},  bus.mem_addr,  32'h0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
        check({tag, "_if_rdata"},  bus.if_rdata,  32'h0);
        check({tag, "_d_rdata"},   bus.d_rdata,   32'h0);
        check({tag, "_if_ready"},  bus.if_ready,  32'h0);
        check({tag, "_d_ready"},   bus.d_ready,   32'h0);
        check({tag, "_bus_err"},   bus.bus_err,   32'h0);
        check({tag, "_owner_d"},   bus.owner_d,   32'h0);
    endtask

    // Memory responder
    initial begin : responder
        int cnt;
        cnt = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.mem_req && rst) begin
                cnt++;
                if (cnt == lat_of(bus.mem_addr)) begin
                    bus.mem_ready = 1'b1;
                    if (bus.mem_we) begin
                        mem_store[bus.mem_addr] = bus.mem_wdata;
                        bus.mem_rdata = 32'hBAD0_BAD0;
                    end else if (mem_store.exists(bus.mem_addr)) begin
                        bus.mem_rdata = mem_store[bus.mem_addr];
                    end else begin
                        bus.mem_rdata = dflt(bus.mem_addr);
                    end
                end else begin
                    bus.mem_ready = 1'b0;
                    bus.mem_rdata = $urandom();
                end
            end else begin
                cnt = 0;
                bus.mem_ready = late_pulse;
                bus.mem_rdata = 32'hFFFF_FFFF;
            end
        end
    end

    // Grant monitor: owner/address per grant and mem_req duration
    initial begin : bus_monitor
        bit prev_req, s_if, s_d, s_we, want_d;
        logic [31:0] s_ia, s_da, s_wd;
        int dur, exp_dur;
        prev_req = 1'b0; s_if = 1'b0; s_d = 1'b0; s_we = 1'b0;
        s_ia = 32'h0; s_da = 32'h0; s_wd = 32'h0; dur = 0; exp_dur = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_req = 1'b0;
                dur      = 0;
                streak_m = 0;
            end else begin
                if (bus.mem_req && !prev_req) begin
                    want_d = s_d && !(s_if && streak_m == STREAK);
                    if (want_d && s_if && streak_m < 15) streak_m++;
                    else if (!want_d) streak_m = 0;
                    check("grant_owner", bus.owner_d, want_d);
                    check("grant_addr", bus.mem_addr, want_d ? s_da : s_ia);
                    check("grant_we", bus.mem_we, want_d ? s_we : 1'b0);
                    if (want_d && s_we) check("grant_wdata", bus.mem_wdata, s_wd);
                    exp_dur = lat_of(want_d ? s_da : s_ia);
                    if (exp_dur > TMO) exp_dur = TMO;
                    dur = 1;
                    if (rec_gseq) gseq = {gseq, bus.owner_d ? "D" : "I"};
                end else if (bus.mem_req) begin
                    dur++;
                end else if (prev_req) begin
                    check("mem_req_cycles", dur, exp_dur);
                end
                prev_req = bus.mem_req;
            end
            s_if = bus.if_req; s_d = bus.d_req; s_we = bus.d_we;
            s_ia = bus.if_addr; s_da = bus.d_addr; s_wd = bus.d_wdata;
        end
    end

    // Response monitor: pops the scoreboard on every ready pulse
    initial begin : resp_monitor
        resp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("stall", bus.stall,
                      (bus.if_req & ~bus.if_ready) | (bus.d_req & ~bus.d_ready));
                check("ready_onehot", bus.if_ready & bus.d_ready, 32'h0);
                if (bus.if_ready) begin
                    if (iq.size() == 0) flag_fail("if_ready_unexpected", "pulse with nothing outstanding");
                    else begin
                        e = iq.pop_front();
                        check("if_rdata", bus.if_rdata, e.rdata);
                        check("if_bus_err", bus.bus_err, e.err);
                    end
                end
                if (bus.d_ready) begin
                    if (dq.size() == 0) flag_fail("d_ready_unexpected", "pulse with nothing outstanding");
                    else begin
                        e = dq.pop_front();
                        check("d_rdata", bus.d_rdata, e.rdata);
                        check("d_bus_err", bus.bus_err, e.err);
                    end
                end
                if (!bus.if_ready && !bus.d_ready) check("bus_err_idle", bus.bus_err, 32'h0);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        mem_store[32'h100] = 32'hDEADBEEF;
        ref_mem[32'h100]   = 32'hDEADBEEF;

        repeat (2) @(negedge clk);
        chk_zero("reset");
        check("reset_stall", bus.stall, 32'h0);
        @(posedge clk); #2 rst = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Single load, two-cycle memory latency
        dir_lat = 2;
        data_txn(1'b0, 32'h100, 32'h0);
        bus.d_req = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Store leaves d_rdata alone
        dir_lat = 1;
        data_txn(1'b1, 32'h200, 32'h12345678);
        bus.d_req = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("store_reached_mem", mem_store.exists(32'h200) ? mem_store[32'h200] : 32'h0, 32'h12345678);

        // Contention with both requesters held high
        gseq = "";
        rec_gseq = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) data_txn(1'b0, 32'h2000 + 32'(i * 4), 32'h0);
                bus.d_req = 1'b0;
            end
            begin
                for (int j = 0; j < 2; j++) fetch_txn(32'h1000 + 32'(j * 4));
                bus.if_req = 1'b0;
            end
        join
        rec_gseq = 1'b0;
        n_checks++;
        if (gseq == "DDDDIDDDDI") n_pass++;
        else $display("FAIL contention_order: got %s required DDDDIDDDDI", gseq);
        repeat (2) @(posedge clk); #1;

        // Fetch timeout, then a late mem_ready must be ignored
        dir_lat = 100;
        fetch_txn(32'h40);
        bus.if_req = 1'b0;
        dir_lat = 0;
        @(posedge clk); #1;
        late_pulse = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("late_ready_mem_req", bus.mem_req, 32'h0);
        end
        late_pulse = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Reset in the middle of a load; the held request restarts afterwards
        dir_lat = 5;
        fork
            begin
                data_txn(1'b0, 32'h300, 32'h0);
                bus.d_req = 1'b0;
            end
            begin
                int n;
                n = 0;
                while (!bus.mem_req && n < 20) begin @(posedge clk); #1; n++; end
                if (!bus.mem_req) flag_fail("mid_busy_grant", "mem_req never rose, required a grant");
                repeat (2) @(posedge clk);
                #2 rst = 1'b0;
                #1 chk_zero("mid_busy_reset");
                @(posedge clk); #2 rst = 1'b1;
            end
        join
        dir_lat = 0;
        repeat (2) @(posedge clk); #1;

        // Randomized concurrent traffic
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    int gap;
                    data_txn(1'($urandom_range(0, 1)), 32'h2000 | (32'($urandom_range(0, 63)) << 2), $urandom());
                    gap = $urandom_range(0, 3);
                    if (gap != 0) begin
                        bus.d_req = 1'b0;
                        repeat (gap) @(posedge clk);
                        #1;
                    end
                end
                bus.d_req = 1'b0;
            end
            begin
                for (int j = 0; j < 150; j++) begin
                    int gap;
                    fetch_txn(32'h1000 | (32'($urandom_range(0, 255)) << 2));
                    gap = $urandom_range(0, 3);
                    if (gap != 0) begin
                        bus.if_req = 1'b0;
                        repeat (gap) @(posedge clk);
                        #1;
                    end
                end
                bus.if_req = 1'b0;
            end
        join

        repeat (5) @(posedge clk); #1;
        check("iq_drained", iq.size(), 32'h0);
        check("dq_drained", dq.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
